reg_writeback_unit: RTL



---
 rtl/wb_pkg.sv | 12 +
 rtl/reg_writeback_unit_fifo.sv | 67 ++++++
 rtl/reg_writeback_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register write-back unit.
package wb_pkg;
    localparam int WB_DW     = 32;
    localparam int WB_AW     = 4;
    localparam int REG_COUNT = 16;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_writeback_unit_fifo.sv
// In-order write-back buffer: up to two enqueues (slot a first, then b) and one pop per cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_push_a,
    input  logic [AW-1:0] i_rd_a,
    input  logic [DW-1:0] i_data_a,
    input  logic          i_push_b,
    input  logic [AW-1:0] i_rd_b,
    input  logic [DW-1:0] i_data_b,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output logic [PW-1:0] o_rptr,
    output logic [AW-1:0] o_rd   [DEPTH],
    output logic [DW-1:0] o_data [DEPTH]
);
    logic [AW-1:0] r_rd   [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_wptr_b;
    logic [1:0]    w_npush;

    assign w_wptr_b = i_push_a ? (r_wptr + PW'(1)) : r_wptr;
    assign w_npush  = {1'b0, i_push_a} + {1'b0, i_push_b};

    // Storage, pointers and occupancy; both pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_push_a) begin
                r_rd[r_wptr]   <= i_rd_a;
                r_data[r_wptr] <= i_data_a;
            end
            if (i_push_b) begin
                r_rd[w_wptr_b]   <= i_rd_b;
                r_data[w_wptr_b] <= i_data_b;
            end
            r_wptr  <= r_wptr + PW'(w_npush);
            if (i_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_npush) - CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_rptr  = r_rptr;
    assign o_rd    = r_rd;
    assign o_data  = r_data;
endmodule

// File: rtl/reg_writeback_unit.sv
// Write-back stage feeding the register file write port; arbitration, pending scoreboard and
// optional forwarding lookup (enabled by defining WB_FWD_EN).
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_rd,
    input  logic [DW-1:0]     alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [AW-1:0]     ld_rd,
    input  logic [DW-1:0]     ld_data,
    output logic              ld_ready,
    output logic [DW-1:0]     rf_I,
    output logic [AW-1:0]     rf_Rc,
    output logic              rf_LE,
    output logic [(1<<AW)-1:0] pending,
    output logic [CW-1:0]     count
`ifdef WB_FWD_EN
    ,
    input  logic [AW-1:0]     fwd_addr,
    output logic              fwd_hit,
    output logic [DW-1:0]     fwd_data
`endif
);
    logic [CW-1:0] w_free;
    logic          w_ld_acc;
    logic          w_alu_acc;
    logic          w_pop;
    logic [PW-1:0] w_rptr;
    logic [AW-1:0] w_rd   [DEPTH];
    logic [DW-1:0] w_data [DEPTH];

    assign w_free    = CW'(DEPTH) - count;
    assign w_ld_acc  = ld_valid & ld_ready;
    assign w_alu_acc = alu_valid & alu_ready;
    assign w_pop     = (count != '0);

    // Free-slot arbitration; a same-cycle pop is deliberately not credited.
    always_comb begin
        if (w_free >= CW'(2)) begin
            ld_ready  = 1'b1;
            alu_ready = 1'b1;
        end else if (w_free == CW'(1)) begin
            ld_ready  = 1'b1;
            alu_ready = ~ld_valid;
        end else begin
            ld_ready  = 1'b0;
            alu_ready = 1'b0;
        end
    end

    wb_fifo #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .i_push_a (w_ld_acc),
        .i_rd_a   (ld_rd),
        .i_data_a (ld_data),
        .i_push_b (w_alu_acc),
        .i_rd_b   (alu_rd),
        .i_data_b (alu_data),
        .i_pop    (w_pop),
        .o_count  (count),
        .o_rptr   (w_rptr),
        .o_rd     (w_rd),
        .o_data   (w_data)
    );

    // Head of the buffer drives the register-file write port.
    always_comb begin
        if (w_pop) begin
            rf_I  = w_data[w_rptr];
            rf_Rc = w_rd[w_rptr];
            rf_LE = 1'b0;
        end else begin
            rf_I  = '0;
            rf_Rc = '0;
            rf_LE = 1'b1;
        end
    end

    // Scoreboard: one-hot OR over the valid entries, walked oldest to youngest.
    always_comb begin
        logic [PW-1:0] idx;
        pending = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_rptr + PW'(k);
            if (CW'(k) < count) begin
                pending[w_rd[idx]] = 1'b1;
            end else begin
                pending = pending;
            end
        end
    end

`ifdef WB_FWD_EN
    // Forwarding lookup; later (younger) matches override earlier ones.
    always_comb begin
        logic [PW-1:0] fidx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fidx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = w_rptr + PW'(k);
            if ((CW'(k) < count) && (w_rd[fidx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = w_data[fidx];
            end else begin
                fwd_hit  = fwd_hit;
            end
        end
    end
`endif
endmodule
